// File: rtl/branch_predictor_pkg.sv
// Shared processor definitions for the branch predictor: counter encodings,
// counter operations and the saturating next-state rule.
package branch_predictor_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } bp_cnt_e;

  typedef enum logic [1:0] {
    CNT_OP_INC,
    CNT_OP_DEC,
    CNT_OP_SET_WEAK_T,
    CNT_OP_SET_STRONG_T
  } bp_cnt_op_e;

  function automatic bp_cnt_e cnt_next(input bp_cnt_e cur, input bp_cnt_op_e op);
    bp_cnt_e nxt;
    nxt = cur;
    case (op)
      CNT_OP_INC:          nxt = (cur == CNT_STRONG_T)  ? CNT_STRONG_T  : bp_cnt_e'(cur + 2'b01);
      CNT_OP_DEC:          nxt = (cur == CNT_STRONG_NT) ? CNT_STRONG_NT : bp_cnt_e'(cur - 2'b01);
      CNT_OP_SET_WEAK_T:   nxt = CNT_WEAK_T;
      CNT_OP_SET_STRONG_T: nxt = CNT_STRONG_T;
      default:             nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Two-bit saturating direction counter for one predictor entry.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  bp_cnt_op_e op,
  output bp_cnt_e    cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= CNT_STRONG_NT;
    end else if (en) begin
      cnt <= cnt_next(cnt, op);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// combinational fetch lookup and a free-running mispredict counter.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  F_pc,
  output logic             F_pred_taken,
  output logic [XLEN-1:0]  F_pred_target,
  input  logic             E_update,
  input  logic [XLEN-1:0]  E_pc,
  input  logic             E_is_jump,
  input  logic             E_taken,
  input  logic [XLEN-1:0]  E_target,
  input  logic             E_mispredict,
  input  logic             invalidate_all,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  if (ENTRIES < 2 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("ENTRIES must be a power of two in 2..256");
  end

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  bp_cnt_e          cnt      [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [1:0]       f_cnt;

  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;

  logic             wr_tag;
  logic             wr_target;
  logic             cnt_en;
  bp_cnt_op_e       cnt_op;

  // Instruction alignment bits never select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{F_pc[1:0], E_pc[1:0]};

  assign f_idx = F_pc[IDX_W+1:2];
  assign f_tag = F_pc[XLEN-1:IDX_W+2];
  assign e_idx = E_pc[IDX_W+1:2];
  assign e_tag = E_pc[XLEN-1:IDX_W+2];

  assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_cnt         = cnt[f_idx];
  assign F_pred_taken  = f_hit && f_cnt[1];
  assign F_pred_target = F_pred_taken ? target_q[f_idx] : '0;

  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // A flush of the whole table swallows any update arriving in the same cycle.
  always_comb begin
    wr_tag    = 1'b0;
    wr_target = 1'b0;
    cnt_en    = 1'b0;
    cnt_op    = CNT_OP_INC;
    if (!invalidate_all && E_update) begin
      if (E_is_jump) begin
        wr_tag    = 1'b1;
        wr_target = 1'b1;
        cnt_en    = 1'b1;
        cnt_op    = CNT_OP_SET_STRONG_T;
      end else if (e_hit) begin
        cnt_en = 1'b1;
        if (E_taken) begin
          wr_target = 1'b1;
          cnt_op    = CNT_OP_INC;
        end else begin
          cnt_op    = CNT_OP_DEC;
        end
      end else if (E_taken) begin
        wr_tag    = 1'b1;
        wr_target = 1'b1;
        cnt_en    = 1'b1;
        cnt_op    = CNT_OP_SET_WEAK_T;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else begin
      if (wr_tag) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
      end
      if (wr_target) begin
        target_q[e_idx] <= E_target;
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    bp_sat_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (cnt_en && (e_idx == IDX_W'(i))),
      .op    (cnt_op),
      .cnt   (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_count <= '0;
    end else if (E_mispredict) begin
      mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_pc;
  logic        F_pred_taken;
  logic [31:0] F_pred_target;
  logic        E_update;
  logic [31:0] E_pc;
  logic        E_is_jump;
  logic        E_taken;
  logic [31:0] E_target;
  logic        E_mispredict;
  logic        invalidate_all;
  logic [31:0] mispredict_count;
  logic        narrow_taken;
  logic [31:0] narrow_target;
  logic [3:0]  narrow_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: one record per table slot, indexed by pc/4 mod 16.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];
  int unsigned m_count;

  logic        exp_taken;
  logic [31:0] exp_target;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .F_pc             (F_pc),
    .F_pred_taken     (F_pred_taken),
    .F_pred_target    (F_pred_target),
    .E_update         (E_update),
    .E_pc             (E_pc),
    .E_is_jump        (E_is_jump),
    .E_taken          (E_taken),
    .E_target         (E_target),
    .E_mispredict     (E_mispredict),
    .invalidate_all   (invalidate_all),
    .mispredict_count (mispredict_count)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut_narrow (
    .clk              (clk),
    .reset            (reset),
    .F_pc             (F_pc),
    .F_pred_taken     (narrow_taken),
    .F_pred_target    (narrow_target),
    .E_update         (E_update),
    .E_pc             (E_pc),
    .E_is_jump        (E_is_jump),
    .E_taken          (E_taken),
    .E_target         (E_target),
    .E_mispredict     (E_mispredict),
    .invalidate_all   (invalidate_all),
    .mispredict_count (narrow_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_cnt[i]    = 0;
    end
    m_count = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic taken,
                                        output logic [31:0] target);
    int i;
    i = int'((pc / 4) % 16);
    taken  = m_valid[i] && (m_tag[i] == pc / 64) && (m_cnt[i] >= 2);
    target = taken ? m_target[i] : 32'h0;
  endfunction

  function automatic void model_update();
    int i;
    bit hit;
    if (E_mispredict) m_count++;
    if (invalidate_all) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      return;
    end
    if (!E_update) return;
    i   = int'((E_pc / 4) % 16);
    hit = m_valid[i] && (m_tag[i] == E_pc / 64);
    if (E_is_jump) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = E_pc / 64;
      m_target[i] = E_target;
      m_cnt[i]    = 3;
    end else if (hit) begin
      if (E_taken) begin
        m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_target[i] = E_target;
      end else begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end
    end else if (E_taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = E_pc / 64;
      m_target[i] = E_target;
      m_cnt[i]    = 2;
    end
  endfunction

  task automatic idle();
    E_update       = 1'b0;
    E_pc           = '0;
    E_is_jump      = 1'b0;
    E_taken        = 1'b0;
    E_target       = '0;
    E_mispredict   = 1'b0;
    invalidate_all = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic jump, input logic taken,
                              input logic [31:0] target);
    E_update  = 1'b1;
    E_pc      = pc;
    E_is_jump = jump;
    E_taken   = taken;
    E_target  = target;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    model_reset();
    F_pc = 32'h100;
    #1;
    tests_run++;
    if (F_pred_taken !== 1'b0 || F_pred_target !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_lookup: got taken=%0b target=%h, expected taken=0 target=0",
               F_pred_taken, F_pred_target);
    end
    tests_run++;
    if (mispredict_count !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d, expected 0", mispredict_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_allocate();
    E_update  = 1'b1;
    E_pc      = 32'h100;
    E_is_jump = 1'b0;
    E_taken   = 1'b1;
    E_target  = 32'h80;
    F_pc      = 32'h100;
    #1;
    model_predict(F_pc, exp_taken, exp_target);
    tests_run++;
    if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
      tests_failed++;
      $display("[TB] FAIL alloc_same_cycle: got taken=%0b target=%h, expected taken=%0b target=%h",
               F_pred_taken, F_pred_target, exp_taken, exp_target);
    end
    tick();
    idle();
    F_pc = 32'h100;
    #1;
    model_predict(F_pc, exp_taken, exp_target);
    tests_run++;
    if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
      tests_failed++;
      $display("[TB] FAIL alloc_next_cycle: got taken=%0b target=%h, expected taken=%0b target=%h",
               F_pred_taken, F_pred_target, exp_taken, exp_target);
    end
  endtask

  task automatic test_saturation();
    bit steps [8];
    steps = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive_update(32'h100, 1'b0, steps[i], 32'h80 + 32'(i * 4));
      F_pc = 32'h100;
      #1;
      model_predict(F_pc, exp_taken, exp_target);
      tests_run++;
      if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
        tests_failed++;
        $display("[TB] FAIL saturation_step%0d: got taken=%0b target=%h, expected taken=%0b target=%h",
                 i, F_pred_taken, F_pred_target, exp_taken, exp_target);
      end
    end
  endtask

  task automatic test_aliasing();
    logic [31:0] pcs [2];
    pcs = '{32'h140, 32'h100};
    drive_update(32'h140, 1'b0, 1'b1, 32'h44);
    for (int i = 0; i < 2; i++) begin
      F_pc = pcs[i];
      #1;
      model_predict(F_pc, exp_taken, exp_target);
      tests_run++;
      if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
        tests_failed++;
        $display("[TB] FAIL alias_%h: got taken=%0b target=%h, expected taken=%0b target=%h",
                 pcs[i], F_pred_taken, F_pred_target, exp_taken, exp_target);
      end
    end
  endtask

  task automatic test_jump_invalidate();
    logic [31:0] pcs [3];
    pcs = '{32'h200, 32'h300, 32'h284};
    drive_update(32'h200, 1'b1, 1'b1, 32'h400);
    drive_update(32'h200, 1'b0, 1'b0, 32'h0);
    drive_update(32'h284, 1'b1, 1'b0, 32'h600);
    for (int i = 0; i < 3; i++) begin
      F_pc = pcs[i];
      #1;
      model_predict(F_pc, exp_taken, exp_target);
      tests_run++;
      if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
        tests_failed++;
        $display("[TB] FAIL jump_%h: got taken=%0b target=%h, expected taken=%0b target=%h",
                 pcs[i], F_pred_taken, F_pred_target, exp_taken, exp_target);
      end
    end
    invalidate_all = 1'b1;
    drive_update(32'h300, 1'b0, 1'b1, 32'h500);
    for (int i = 0; i < 3; i++) begin
      F_pc = pcs[i];
      #1;
      model_predict(F_pc, exp_taken, exp_target);
      tests_run++;
      if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
        tests_failed++;
        $display("[TB] FAIL invalidate_%h: got taken=%0b target=%h, expected taken=%0b target=%h",
                 pcs[i], F_pred_taken, F_pred_target, exp_taken, exp_target);
      end
    end
  endtask

  task automatic test_mispredict_and_reset();
    int pulses [2];
    logic [31:0] pcs [3];
    pulses = '{5, 12};
    pcs    = '{32'h100, 32'h140, 32'h200};
    for (int p = 0; p < 2; p++) begin
      E_mispredict = 1'b1;
      for (int i = 0; i < pulses[p]; i++) tick();
      idle();
      tests_run++;
      if (mispredict_count !== 32'(m_count) || narrow_count !== 4'(m_count % 16)) begin
        tests_failed++;
        $display("[TB] FAIL mispredict_count_%0d: got wide=%0d narrow=%0d, expected wide=%0d narrow=%0d",
                 p, mispredict_count, narrow_count, m_count, m_count % 16);
      end
    end
    drive_update(32'h100, 1'b1, 1'b1, 32'h900);
    drive_update(32'h200, 1'b1, 1'b1, 32'h910);
    E_update     = 1'b1;
    E_pc         = 32'h140;
    E_taken      = 1'b1;
    E_target     = 32'h920;
    E_mispredict = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (mispredict_count !== 32'h0 || narrow_count !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_count: got wide=%0d narrow=%0d, expected 0",
               mispredict_count, narrow_count);
    end
    for (int i = 0; i < 3; i++) begin
      F_pc = pcs[i];
      #1;
      tests_run++;
      if (F_pred_taken !== 1'b0 || F_pred_target !== 32'h0) begin
        tests_failed++;
        $display("[TB] FAIL async_reset_%h: got taken=%0b target=%h, expected taken=0 target=0",
                 pcs[i], F_pred_taken, F_pred_target);
      end
    end
    tick();
    idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
    F_pc = 32'h140;
    #1;
    model_predict(F_pc, exp_taken, exp_target);
    tests_run++;
    if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
      tests_failed++;
      $display("[TB] FAIL reset_discard: got taken=%0b target=%h, expected taken=%0b target=%h",
               F_pred_taken, F_pred_target, exp_taken, exp_target);
    end
    drive_update(32'h140, 1'b0, 1'b1, 32'h920);
    F_pc = 32'h140;
    #1;
    model_predict(F_pc, exp_taken, exp_target);
    tests_run++;
    if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_update: got taken=%0b target=%h, expected taken=%0b target=%h",
               F_pred_taken, F_pred_target, exp_taken, exp_target);
    end
  endtask

  // Small tag pool and random low bits so hits, aliasing and misses all occur.
  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [3];
    tags = '{32'h1, 32'h2, 32'h37};
    return (tags[$urandom_range(0, 2)] << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      E_update       = ($urandom_range(0, 3) != 0);
      E_pc           = rand_pc();
      E_is_jump      = ($urandom_range(0, 7) == 0);
      E_taken        = $urandom_range(0, 1) == 1;
      E_target       = $urandom;
      E_mispredict   = $urandom_range(0, 1) == 1;
      invalidate_all = ($urandom_range(0, 31) == 0);
      F_pc           = ($urandom_range(0, 1) == 1) ? E_pc : rand_pc();
      #1;
      model_predict(F_pc, exp_taken, exp_target);
      tests_run++;
      if (F_pred_taken !== exp_taken || F_pred_target !== exp_target) begin
        tests_failed++;
        $display("[TB] FAIL random_lookup_%0d pc=%h: got taken=%0b target=%h, expected taken=%0b target=%h",
                 n, F_pc, F_pred_taken, F_pred_target, exp_taken, exp_target);
      end
      tests_run++;
      if (mispredict_count !== 32'(m_count) || narrow_count !== 4'(m_count % 16)) begin
        tests_failed++;
        $display("[TB] FAIL random_count_%0d: got wide=%0d narrow=%0d, expected wide=%0d narrow=%0d",
                 n, mispredict_count, narrow_count, m_count, m_count % 16);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    F_pc  = '0;
    idle();
    #12;
    test_reset();
    test_allocate();
    test_saturation();
    test_aliasing();
    test_jump_invalidate();
    test_mispredict_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
